// File: rtl/arb_mux_pkg.sv
// Shared definitions for the N-channel arbitrated output mux.
package arb_mux_pkg;

  // Grant policy selected by mode_i.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel after idx, wrapping at n-1 -> 0. The result is always
  // below n, including when n is not a power of two.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_picker.sv
// Wrapped priority search: the first asserted req at or after ptr wins,
// ascending and wrapping at CHANNELS-1 -> 0. Purely combinational.
module rr_picker #(
  parameter  int CHANNELS = 3,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                gnt_valid,
  output logic [SEL_W-1:0]    gnt_idx
);

  // Scan from the farthest offset down to ptr so the nearest request is
  // written last and therefore wins.
  always_comb begin
    int         idx;
    logic [SEL_W-1:0] idx_w;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      idx_w = SEL_W'(idx);
      if (req[idx_w]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_w;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel selector with a single registered output stage and valid/ready
// handshake on both sides. Channel choice is either a fixed index or a
// round-robin search; backpressure stalls the winner without losing data.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int SIZE     = 32,
  parameter  int CHANNELS = 3,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CHANNELS-1:0]        valid_i,
  input  logic [CHANNELS*SIZE-1:0]   data_i,
  output logic [CHANNELS-1:0]        ready_o,
  input  logic                       mode_i,
  input  logic [SEL_W-1:0]           select_i,
  output logic                       valid_o,
  output logic [SIZE-1:0]            data_o,
  output logic [SEL_W-1:0]           grant_o,
  input  logic                       ready_i
);

  logic             vld_p0;
  logic [SIZE-1:0]  data_p0;
  logic [SEL_W-1:0] grant_p0;
  logic [SEL_W-1:0] rr_ptr;

  logic             can_load;
  logic             load;
  logic             fix_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [SIZE-1:0]  gnt_data;

  rr_picker #(
    .CHANNELS (CHANNELS)
  ) u_picker (
    .req       (valid_i),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // The register can take a new word when empty or when it drains this cycle.
  assign can_load = !vld_p0 || ready_i;

  // Fixed-mode decode: an out-of-range select grants nothing.
  always_comb begin
    fix_valid = 1'b0;
    if (int'(select_i) < CHANNELS) fix_valid = valid_i[select_i];
  end

  // Pick the grant source according to the current mode.
  always_comb begin
    gnt_valid = fix_valid;
    gnt_idx   = select_i;
    if (mode_i == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end
  end

  // One-hot accept toward the producers; held low while reset is asserted.
  always_comb begin
    ready_o = '0;
    if (rst_i && can_load && gnt_valid) ready_o[gnt_idx] = 1'b1;
  end

  assign load     = |(valid_i & ready_o);
  assign gnt_data = data_i[int'(gnt_idx)*SIZE +: SIZE];

  // ---- stage p0: output register, control half ----
  // Valid flag and round-robin pointer; fixed-mode loads leave the pointer alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p0 <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (load) vld_p0 <= 1'b1;
      else if (vld_p0 && ready_i) vld_p0 <= 1'b0;
      if (load && mode_i == MODE_RR)
        rr_ptr <= SEL_W'(wrap_next(int'(gnt_idx), CHANNELS));
    end
  end

  // Data and grant index capture; they hold across drains and stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_p0  <= '0;
      grant_p0 <= '0;
    end else if (load) begin
      data_p0  <= gnt_data;
      grant_p0 <= gnt_idx;
    end
  end

  assign valid_o = vld_p0;
  assign data_o  = data_p0;
  assign grant_o = grant_p0;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n with CHANNELS=3, SIZE=3, channel data {6,5,4}.
module tb_arb_mux_n;

  localparam int CH    = 3;
  localparam int SZ    = 3;
  localparam int SEL_W = $clog2(CH);

  logic              clk_i;
  logic              rst_i;
  logic [CH-1:0]     valid_i;
  logic [CH*SZ-1:0]  data_i;
  logic [CH-1:0]     ready_o;
  logic              mode_i;
  logic [SEL_W-1:0]  select_i;
  logic              valid_o;
  logic [SZ-1:0]     data_o;
  logic [SEL_W-1:0]  grant_o;
  logic              ready_i;

  int total = 0;
  int bad   = 0;

  arb_mux_n #(.SIZE(SZ), .CHANNELS(CH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .mode_i   (mode_i),
    .select_i (select_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .grant_o  (grant_o),
    .ready_i  (ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int g);
    chk({tag, ".valid"}, int'(valid_o), v);
    chk({tag, ".data"},  int'(data_o),  d);
    chk({tag, ".grant"}, int'(grant_o), g);
  endtask

  initial begin
    // Reset held with live inputs.
    rst_i    = 1'b0;
    valid_i  = 3'b111;
    data_i   = {3'd6, 3'd5, 3'd4};
    mode_i   = 1'b0;
    select_i = 2'd0;
    ready_i  = 1'b1;
    #2;
    chk_out("rst0", 0, 0, 0);
    chk("rst0.ready", int'(ready_o), 0);
    tick();
    tick();
    chk_out("rst1", 0, 0, 0);
    chk("rst1.ready", int'(ready_o), 0);

    // Release, load one word, then reset mid-cycle.
    rst_i = 1'b1;
    #1;
    chk("rel.ready", int'(ready_o), 3'b001);
    tick();
    chk_out("preload", 1, 4, 0);
    #2;
    rst_i = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    chk("async_rst.ready", int'(ready_o), 0);
    rst_i = 1'b1;

    // Fixed mode: select 0, 1, 2.
    for (int s = 0; s < 3; s++) begin
      select_i = SEL_W'(s);
      #1;
      chk($sformatf("fix%0d.ready", s), int'(ready_o), 1 << s);
      tick();
      chk_out($sformatf("fix%0d", s), 1, 4 + s, s);
    end
    // Out-of-range select: no accept, register drains.
    select_i = 2'd3;
    #1;
    chk("fix3.ready", int'(ready_o), 0);
    tick();
    chk_out("fix3.drain", 0, 6, 2);

    // Round-robin, all valid.
    mode_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr_all%0d", i), 1, 4 + (i % 3), i % 3);
    end

    // Round-robin, only ch0 and ch2.
    valid_i = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("rr_02_%0d", i), 1, (i % 2 == 0) ? 4 : 6, (i % 2 == 0) ? 0 : 2);
    end
    valid_i = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rr_2_%0d", i), 1, 6, 2);
    end

    // Backpressure from a clean reset.
    rst_i = 1'b0;
    #1;
    rst_i   = 1'b1;
    valid_i = 3'b111;
    tick();
    chk_out("bp.load", 1, 4, 0);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.ready", i), int'(ready_o), 0);
      tick();
      chk_out($sformatf("bp%0d", i), 1, 4, 0);
    end
    ready_i = 1'b1;
    tick();
    chk_out("bp.rel1", 1, 5, 1);
    tick();
    chk_out("bp.rel2", 1, 6, 2);

    // Mode switch keeps the round-robin pointer.
    tick();
    chk_out("ms.rr0", 1, 4, 0);
    tick();
    chk_out("ms.rr1", 1, 5, 1);
    mode_i   = 1'b0;
    select_i = 2'd0;
    tick();
    chk_out("ms.fix0", 1, 4, 0);
    mode_i = 1'b1;
    tick();
    chk_out("ms.rr2", 1, 6, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
